// File: rtl/instruction_fetch_if.sv
// Instruction memory read channel between the fetch stage and the memory controller.
interface instruction_fetch_if #(
    parameter int MC_AW = 18
);
    logic             if_mc_en;
    logic [MC_AW-1:0] if_mc_addr;
    logic [31:0]      mc_if_data;
    logic             mc_if_ready;

    modport master (
        output if_mc_en,
        output if_mc_addr,
        input  mc_if_data,
        input  mc_if_ready
    );

    modport slave (
        input  if_mc_en,
        input  if_mc_addr,
        output mc_if_data,
        output mc_if_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, reads instruction memory over a ready handshake,
// loads IF/ID, applies delayed-branch redirects and parks one word in a skid buffer.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int          MC_AW      = 18
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ex_if_stall,
    input  logic                id_if_selpcsource,
    input  logic [1:0]          id_if_selpctype,
    input  logic [31:0]         id_if_rega,
    input  logic [31:0]         id_if_pcimd2ext,
    input  logic [31:0]         id_if_pcindex,
    instruction_fetch_if.master mc,
    output logic [31:0]         if_id_instruc,
    output logic [31:0]         if_id_nextpc,
    output logic                if_id_valid
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic [31:0] target_raw_s;
    logic [31:0] target_s;
    logic [31:0] redirect_pc_r;
    logic        redirect_pend_r;
    logic [31:0] buf_instruc_r;
    logic [31:0] buf_nextpc_r;
    logic        redirect_s;
    logic        advance_s;
    logic        capture_s;
    logic        bubble_s;
    logic        from_buf_s;
    logic        pc_load_s;
    logic        en_s;

    assign pc_plus4_s    = pc_r + 32'd4;
    assign mc.if_mc_en   = en_s;
    assign mc.if_mc_addr = pc_r[MC_AW+1:2];

    // Redirect target mux and the PC to use once a memory word is accepted
    always_comb begin
        target_raw_s = EXC_VECTOR;
        target_s     = 32'h0000_0000;
        pc_next_s    = pc_plus4_s;
        redirect_s   = if_id_valid & id_if_selpcsource;
        case (id_if_selpctype)
            2'b00:   target_raw_s = id_if_pcimd2ext;
            2'b01:   target_raw_s = id_if_rega;
            2'b10:   target_raw_s = id_if_pcindex;
            2'b11:   target_raw_s = EXC_VECTOR;
            default: target_raw_s = EXC_VECTOR;
        endcase
        target_s = target_raw_s & 32'hFFFF_FFFC;
        if (redirect_s) begin
            pc_next_s = target_s;
        end else if (redirect_pend_r) begin
            pc_next_s = redirect_pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        en_s        = 1'b0;
        advance_s   = 1'b0;
        capture_s   = 1'b0;
        bubble_s    = 1'b0;
        from_buf_s  = 1'b0;
        pc_load_s   = 1'b0;
        case (state_r)
            FETCH: begin
                en_s = ~reset;
                if (mc.mc_if_ready) begin
                    pc_load_s = 1'b1;
                    if (ex_if_stall) begin
                        capture_s   = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        advance_s   = 1'b1;
                        state_nxt_s = FETCH;
                    end
                end else if (!ex_if_stall) begin
                    bubble_s = 1'b1;
                end else begin
                    bubble_s = 1'b0;
                end
            end
            HOLD: begin
                if (!ex_if_stall) begin
                    advance_s   = 1'b1;
                    from_buf_s  = 1'b1;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = FETCH;
            end
        endcase
    end

    // PC, IF/ID, skid buffer and pending-redirect registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r            <= RESET_PC & 32'hFFFF_FFFC;
            if_id_instruc   <= 32'h0000_0000;
            if_id_nextpc    <= 32'h0000_0000;
            if_id_valid     <= 1'b0;
            redirect_pend_r <= 1'b0;
            redirect_pc_r   <= 32'h0000_0000;
            buf_instruc_r   <= 32'h0000_0000;
            buf_nextpc_r    <= 32'h0000_0000;
        end else begin
            // In HOLD the PC is already past the buffered word; only a redirect moves it
            if (pc_load_s) begin
                pc_r <= pc_next_s;
            end else if (from_buf_s && redirect_s) begin
                pc_r <= target_s;
            end
            if (advance_s) begin
                if_id_instruc <= from_buf_s ? buf_instruc_r : mc.mc_if_data;
                if_id_nextpc  <= from_buf_s ? buf_nextpc_r : pc_plus4_s;
                if_id_valid   <= 1'b1;
            end else if (bubble_s) begin
                if_id_instruc <= 32'h0000_0000;
                if_id_valid   <= 1'b0;
            end
            if (capture_s) begin
                buf_instruc_r <= mc.mc_if_data;
                buf_nextpc_r  <= pc_plus4_s;
            end
            if (advance_s || capture_s) begin
                redirect_pend_r <= 1'b0;
            end else if (bubble_s && redirect_s) begin
                redirect_pend_r <= 1'b1;
                redirect_pc_r   <= target_s;
            end
        end
    end

endmodule
